// File: rtl/masked_aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : masked_aes_pkg
// Description : Shared types and helpers for the two-random-bit masked AES
//               datapath: sequencer state encoding, the per-bit mask class
//               table and the class-mask expansion function.
// Revision    : 1.0 - initial release
// ============================================================================
package masked_aes_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        DRAIN = 3'd2,
        REMA  = 3'd3,
        REMB  = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Mask class of each bit position: 1 = m1, 2 = m2, 3 = m3 (m1 ^ m2).
    // Index 0 is bit 0. The S-box output shares the input's classes.
    localparam logic [1:0] MASK_CLASS [8] = '{
        2'd2, 2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2
    };

    // Expand a (m1, m2) pair into the 8-bit mask vector applied to a byte.
    function automatic logic [7:0] class_mask(input logic m1, input logic m2);
        logic [7:0] v;
        v = '0;
        for (int b = 0; b < 8; b++) begin
            case (MASK_CLASS[b])
                2'd1:    v[b] = m1;
                2'd2:    v[b] = m2;
                2'd3:    v[b] = m1 ^ m2;
                default: v[b] = 1'b0;
            endcase
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/masked_remask_byte.sv
`default_nettype none
// ============================================================================
// Module      : masked_remask_byte
// Description : One step of the two-step byte remask. rem_sel=0 adds the
//               new mask pair, rem_sel=1 removes the old pair. Only one
//               mask vector is ever XORed in a given step, so the byte is
//               never exposed with both pairs cancelling in one gate level.
// Revision    : 1.0 - initial release
// ============================================================================
module masked_remask_byte
    import masked_aes_pkg::*;
(
    input  logic [7:0] din,
    input  logic       add_m1,
    input  logic       add_m2,
    input  logic       rem_m1,
    input  logic       rem_m2,
    input  logic       rem_sel,
    output logic [7:0] dout
);

    logic [7:0] step_mask;

    // Select the mask vector for the current step, then apply it.
    always_comb begin
        step_mask = rem_sel ? class_mask(rem_m1, rem_m2)
                            : class_mask(add_m1, add_m2);
        dout      = din ^ step_mask;
    end

endmodule
`default_nettype wire

// File: rtl/masked_subbytes_seq.sv
`default_nettype none
// ============================================================================
// Module      : masked_subbytes_seq
// Description : Sequencer around the two-random-bit masked AES S-box.
//               Latches a 128-bit masked state, streams its 16 bytes one per
//               cycle into the S-box, collects the results in place and
//               presents the masked SubBytes state.
//               Optional build macro MASKED_SUBBYTES_REMASK_EN: when defined,
//               the result is refreshed to the fresh (rnd_m1, rnd_m2) pair
//               in two registered steps (add new, then remove old).
// Revision    : 1.0 - initial release
// ============================================================================
module masked_subbytes_seq
    import masked_aes_pkg::*;
#(
    parameter int SBOX_LAT = 0   // S-box pipeline depth, 0..4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_m1,
    input  logic         in_m2,
    input  logic         rnd_m1,
    input  logic         rnd_m2,
    output logic [7:0]   sb_in,
    output logic         sb_m1,
    output logic         sb_m2,
    input  logic [7:0]   sb_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_m1,
    output logic         out_m2
);

`ifdef MASKED_SUBBYTES_REMASK_EN
    localparam state_e AFTER_SBOX = REMA;
`else
    localparam state_e AFTER_SBOX = DONE;
`endif
    localparam logic [2:0] DRAIN_LAST = 3'(SBOX_LAT - 1);

    state_e       st_q, st_d;
    logic [3:0]   cnt_q, cnt_d;       // byte being fed
    logic [2:0]   drain_q, drain_d;   // cycles spent in DRAIN
    logic [127:0] data_q, data_d;     // input bytes, overwritten by results
    logic         m1_q, m1_d, m2_q, m2_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [7:0]   sb_in_q, sb_in_d;
    logic         sb_m1_q, sb_m1_d, sb_m2_q, sb_m2_d;
    logic         out_m1_q, out_m1_d, out_m2_q, out_m2_d;
    logic         fin_m1, fin_m2;

    // Capture position: cycles since the first feed cycle; the byte whose
    // result is on sb_out now was fed SBOX_LAT cycles earlier.
    logic [4:0]   cap_pos;
    logic [5:0]   cap_diff;
    logic         cap_en;
    logic [3:0]   cap_idx;

`ifdef MASKED_SUBBYTES_REMASK_EN
    logic         n1_q, n1_d, n2_q, n2_d;   // fresh mask pair
    logic [127:0] rem_out;

    for (genvar i = 0; i < 16; i++) begin : g_remask
        masked_remask_byte u_remask (
            .din     (data_q[8*i +: 8]),
            .add_m1  (n1_q),
            .add_m2  (n2_q),
            .rem_m1  (m1_q),
            .rem_m2  (m2_q),
            .rem_sel (st_q == REMB),
            .dout    (rem_out[8*i +: 8])
        );
    end
`else
    logic         unused_rnd;
    assign unused_rnd = rnd_m1 ^ rnd_m2;
`endif

    // Next-state, datapath and registered-output computation.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        data_d  = data_q;
        m1_d    = m1_q;
        m2_d    = m2_q;
`ifdef MASKED_SUBBYTES_REMASK_EN
        n1_d    = n1_q;
        n2_d    = n2_q;
`endif

        cap_pos  = (st_q == DRAIN) ? (5'd16 + {2'b00, drain_q}) : {1'b0, cnt_q};
        cap_diff = {1'b0, cap_pos} - 6'(SBOX_LAT);
        cap_en   = ((st_q == FEED) || (st_q == DRAIN)) && !cap_diff[5];
        cap_idx  = cap_diff[3:0];

        case (st_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_state;
                    m1_d    = in_m1;
                    m2_d    = in_m2;
`ifdef MASKED_SUBBYTES_REMASK_EN
                    n1_d    = rnd_m1;
                    n2_d    = rnd_m2;
`endif
                    cnt_d   = 4'd0;
                    drain_d = 3'd0;
                    st_d    = FEED;
                end
            end
            FEED: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'hF) begin
                    st_d = (SBOX_LAT > 0) ? DRAIN : AFTER_SBOX;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 3'd1;
                if (drain_q == DRAIN_LAST) begin
                    st_d = AFTER_SBOX;
                end
            end
`ifdef MASKED_SUBBYTES_REMASK_EN
            REMA: begin
                data_d = rem_out;
                st_d   = REMB;
            end
            REMB: begin
                data_d = rem_out;
                st_d   = DONE;
            end
`endif
            DONE: begin
                if (out_ready) begin
                    st_d = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase

        // Results land in place; the slot was already fed, so no later
        // feed reads it.
        if (cap_en) begin
            data_d[{cap_idx, 3'b000} +: 8] = sb_out;
        end

`ifdef MASKED_SUBBYTES_REMASK_EN
        fin_m1 = n1_d;
        fin_m2 = n2_d;
`else
        fin_m1 = m1_d;
        fin_m2 = m2_d;
`endif

        in_ready_d  = (st_d == IDLE);
        out_valid_d = (st_d == DONE);
        sb_in_d     = (st_d == FEED) ? data_d[{cnt_d, 3'b000} +: 8] : 8'h00;
        sb_m1_d     = ((st_d == FEED) || (st_d == DRAIN)) ? m1_d : 1'b0;
        sb_m2_d     = ((st_d == FEED) || (st_d == DRAIN)) ? m2_d : 1'b0;
        out_m1_d    = (st_d == DONE) ? fin_m1 : 1'b0;
        out_m2_d    = (st_d == DONE) ? fin_m2 : 1'b0;
    end

    // State, data and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q        <= IDLE;
            cnt_q       <= '0;
            drain_q     <= '0;
            data_q      <= '0;
            m1_q        <= 1'b0;
            m2_q        <= 1'b0;
`ifdef MASKED_SUBBYTES_REMASK_EN
            n1_q        <= 1'b0;
            n2_q        <= 1'b0;
`endif
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sb_in_q     <= '0;
            sb_m1_q     <= 1'b0;
            sb_m2_q     <= 1'b0;
            out_m1_q    <= 1'b0;
            out_m2_q    <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            data_q      <= data_d;
            m1_q        <= m1_d;
            m2_q        <= m2_d;
`ifdef MASKED_SUBBYTES_REMASK_EN
            n1_q        <= n1_d;
            n2_q        <= n2_d;
`endif
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sb_in_q     <= sb_in_d;
            sb_m1_q     <= sb_m1_d;
            sb_m2_q     <= sb_m2_d;
            out_m1_q    <= out_m1_d;
            out_m2_q    <= out_m2_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sb_in     = sb_in_q;
    assign sb_m1     = sb_m1_q;
    assign sb_m2     = sb_m2_q;
    assign out_m1    = out_m1_q;
    assign out_m2    = out_m2_q;
    // Only a finished result is ever visible on the output bus.
    assign out_state = out_valid_q ? data_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_masked_subbytes_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_masked_subbytes_seq
// Description : Directed self-checking bench. Two sequencers (S-box latency
//               0 and 2) each drive a behavioural masked S-box model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_masked_subbytes_seq;

`ifdef MASKED_SUBBYTES_REMASK_EN
    localparam bit REM = 1'b1;
`else
    localparam bit REM = 1'b0;
`endif

    logic         clk, rst_n;
    logic [127:0] in_state;
    logic         in_m1, in_m2, rnd_m1, rnd_m2, out_ready;

    logic         in_valid_a, in_ready_a, sb_m1_a, sb_m2_a, out_valid_a, out_m1_a, out_m2_a;
    logic [7:0]   sb_in_a, sb_out_a;
    logic [127:0] out_state_a;
    logic         in_valid_b, in_ready_b, sb_m1_b, sb_m2_b, out_valid_b, out_m1_b, out_m2_b;
    logic [7:0]   sb_in_b, sb_out_b, pipe1_b, pipe2_b;
    logic [127:0] out_state_b;

    int n_checks = 0;
    int n_errors = 0;

    masked_subbytes_seq #(.SBOX_LAT(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_state(in_state), .in_m1(in_m1), .in_m2(in_m2), .rnd_m1(rnd_m1), .rnd_m2(rnd_m2),
        .sb_in(sb_in_a), .sb_m1(sb_m1_a), .sb_m2(sb_m2_a), .sb_out(sb_out_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_state(out_state_a),
        .out_m1(out_m1_a), .out_m2(out_m2_a)
    );

    masked_subbytes_seq #(.SBOX_LAT(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_state(in_state), .in_m1(in_m1), .in_m2(in_m2), .rnd_m1(rnd_m1), .rnd_m2(rnd_m2),
        .sb_in(sb_in_b), .sb_m1(sb_m1_b), .sb_m2(sb_m2_b), .sb_out(sb_out_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_state(out_state_b),
        .out_m1(out_m1_b), .out_m2(out_m2_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural masked S-box ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Bit classes, MSB first: b7 m2, b6 m1, b5 m2, b4 m1, b3 m1, b2 m3, b1 m3, b0 m2
    function automatic logic [7:0] tb_mask(input logic m1, input logic m2);
        return {m2, m1, m2, m1, m1, m1 ^ m2, m1 ^ m2, m2};
    endfunction

    function automatic logic [7:0] msbox(input logic [7:0] x, input logic m1, input logic m2);
        return aes_sbox(x ^ tb_mask(m1, m2)) ^ tb_mask(m1, m2);
    endfunction

    always_comb sb_out_a = msbox(sb_in_a, sb_m1_a, sb_m2_a);

    always_ff @(posedge clk) begin
        pipe1_b <= msbox(sb_in_b, sb_m1_b, sb_m2_b);
        pipe2_b <= pipe1_b;
    end
    assign sb_out_b = pipe2_b;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one state on DUT a (sel_b=0) or b (sel_b=1); return the cycle
    // offset from t0 at which out_valid is first seen, the result, and the
    // S-box drive observed in cycle t0+1.
    task automatic run(input bit sel_b, input logic [127:0] st, input logic m1, input logic m2,
                       input logic r1, input logic r2, output int cyc,
                       output logic [127:0] ost, output logic [1:0] om,
                       output logic [7:0] first_sb, output logic [1:0] first_sbm);
        int n;
        n = 0;
        while (!(sel_b ? in_ready_b : in_ready_a) && n < 50) begin
            tick();
            n++;
        end
        in_state = st;
        in_m1 = m1;
        in_m2 = m2;
        rnd_m1 = r1;
        rnd_m2 = r2;
        if (sel_b) in_valid_b = 1'b1; else in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        cyc = 1;
        first_sb  = sel_b ? sb_in_b : sb_in_a;
        first_sbm = sel_b ? {sb_m1_b, sb_m2_b} : {sb_m1_a, sb_m2_a};
        while (!(sel_b ? out_valid_b : out_valid_a) && cyc < 100) begin
            tick();
            cyc++;
        end
        ost = sel_b ? out_state_b : out_state_a;
        om  = sel_b ? {out_m1_b, out_m2_b} : {out_m1_a, out_m2_a};
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int           cyc;
        logic [127:0] ost;
        logic [1:0]   om;
        logic [7:0]   fsb;
        logic [1:0]   fsbm;
        logic         seen;
        int           lat0;
        logic [127:0] st2_in, st2_exp, st3_in, st3_exp;
        logic [1:0]   m3_exp;

        lat0    = REM ? 19 : 17;
        st2_in  = {{13{8'h00}}, 8'h53, 8'h01, 8'h00};
        st2_exp = {{13{8'h63}}, 8'hED, 8'h7C, 8'h63};
        st3_in  = {16{8'h5E}};
        st3_exp = REM ? {16{8'hC4}} : {16{8'h3D}};
        m3_exp  = REM ? 2'b01 : 2'b10;

        rst_n = 1'b0;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        in_state = '0; in_m1 = 1'b0; in_m2 = 1'b0; rnd_m1 = 1'b0; rnd_m2 = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        chk("reset_in_ready", 128'(in_ready_a), 128'd1);
        chk("reset_out_valid", 128'(out_valid_a), 128'd0);
        chk("reset_sb", 128'({sb_in_a, sb_m1_a, sb_m2_a}), 128'd0);
        chk("reset_out", {out_state_a[125:0], out_m1_a, out_m2_a}, 128'd0);
        rst_n = 1'b1;
        tick();

        // all-zero state, zero masks
        run(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, cyc, ost, om, fsb, fsbm);
        chk("t1_latency", 128'(cyc), 128'(lat0));
        chk("t1_state", ost, {16{8'h63}});
        chk("t1_masks", 128'(om), 128'd0);
        tick();

        // distinct bytes check byte ordering
        run(1'b0, st2_in, 1'b0, 1'b0, 1'b0, 1'b0, cyc, ost, om, fsb, fsbm);
        chk("t2_state", ost, st2_exp);
        chk("t2_sb_first", 128'(fsb), 128'h00);
        tick();

        // masked zero bytes, hold result with out_ready low
        out_ready = 1'b0;
        run(1'b0, st3_in, 1'b1, 1'b0, 1'b0, 1'b1, cyc, ost, om, fsb, fsbm);
        chk("t3_latency", 128'(cyc), 128'(lat0));
        chk("t3_sb_first", 128'(fsb), 128'h5E);
        chk("t3_sb_masks", 128'(fsbm), 128'b10);
        chk("t3_state", ost, st3_exp);
        chk("t3_masks", 128'(om), 128'(m3_exp));
        chk("t3_sb_idle", 128'({sb_in_a, sb_m1_a, sb_m2_a}), 128'd0);
        repeat (10) tick();
        chk("hold_state", out_state_a, st3_exp);
        chk("hold_masks", 128'({out_m1_a, out_m2_a}), 128'(m3_exp));
        chk("hold_in_ready", 128'(in_ready_a), 128'd0);
        chk("hold_out_valid", 128'(out_valid_a), 128'd1);
        out_ready = 1'b1;
        tick();
        chk("release_in_ready", 128'(in_ready_a), 128'd1);
        chk("release_out_valid", 128'(out_valid_a), 128'd0);

        // reset in the middle of feeding
        in_state = st3_in; in_m1 = 1'b1; in_m2 = 1'b0;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_in_ready", 128'(in_ready_a), 128'd1);
        chk("rst_out_valid", 128'(out_valid_a), 128'd0);
        chk("rst_sb_in", 128'(sb_in_a), 128'd0);
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (out_valid_a) seen = 1'b1;
        end
        chk("rst_no_partial", 128'(seen), 128'd0);

        // S-box latency 2
        run(1'b1, st3_in, 1'b1, 1'b0, 1'b0, 1'b1, cyc, ost, om, fsb, fsbm);
        chk("lat2_latency", 128'(cyc), 128'(lat0 + 2));
        chk("lat2_state", ost, st3_exp);
        chk("lat2_masks", 128'(om), 128'(m3_exp));
        tick();
        run(1'b1, st2_in, 1'b0, 1'b0, 1'b0, 1'b0, cyc, ost, om, fsb, fsbm);
        chk("lat2_order", ost, st2_exp);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
